// File: rtl/conv_stream_pkg.sv
// Shared state type and sizing helpers for the convolution core stream driver.
package conv_stream_pkg;

  typedef enum logic [1:0] {LOAD, RUN, SEND} conv_stream_state_t;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned ceil_div8(input int unsigned nbits);
    return (nbits + 32'd7) / 32'd8;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv_result_serializer.sv
// Captures the core result image and streams it out LSB-first as valid/ready bytes.
module conv_result_serializer
  import conv_stream_pkg::*;
#(
  parameter int unsigned PIX_OUT = 784,
  parameter int unsigned CNT_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_capture,
  input  logic [PIX_OUT-1:0] i_result,
  input  logic               i_out_ready,
  output logic [7:0]         o_out_data,
  output logic               o_out_valid,
  output logic               o_done_c
);

  localparam int unsigned NBYTES = ceil_div8(PIX_OUT);
  localparam int unsigned RES_W  = NBYTES * BYTE_W;
  localparam int unsigned RIDX_W = $clog2(RES_W);

  logic [RES_W-1:0]  r_result;
  logic [CNT_W-1:0]  r_idx;
  logic [7:0]        r_out_data;
  logic              r_out_valid;

  logic [RES_W-1:0]  w_cap_pad;
  logic [CNT_W-1:0]  w_idx_nxt;
  logic [RIDX_W-1:0] w_base_nxt;
  logic              w_fire;
  logic              w_last;

  // Result is zero-extended to whole bytes so the tail of the last byte reads 0.
  assign w_cap_pad  = RES_W'(i_result);
  assign w_idx_nxt  = r_idx + CNT_W'(1);
  assign w_base_nxt = RIDX_W'({w_idx_nxt, 3'b000});
  assign w_fire     = r_out_valid && i_out_ready;
  assign w_last     = (r_idx == CNT_W'(NBYTES - 1));
  assign o_done_c   = w_fire && w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_idx       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (i_capture) begin
      r_result    <= w_cap_pad;
      r_idx       <= '0;
      r_out_data  <= w_cap_pad[7:0];
      r_out_valid <= 1'b1;
    end else if (w_fire) begin
      if (w_last) begin
        r_idx       <= '0;
        r_out_valid <= 1'b0;
      end else begin
        r_idx      <= w_idx_nxt;
        r_out_data <= r_result[w_base_nxt +: 8];
      end
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;

endmodule

// File: rtl/conv_stream_ctrl.sv
// Byte-stream front end for the binary 3x3 convolution core: loads weights and
// images, holds the core's start level while it runs, then drains the result.
module conv_stream_ctrl
  import conv_stream_pkg::*;
#(
  parameter int unsigned IC           = 8,
  parameter int unsigned IMG_IN_SIZE  = 30,
  parameter int unsigned IMG_OUT_SIZE = IMG_IN_SIZE - 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [7:0]                           in_data,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  output logic [7:0]                           out_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [IC*9-1:0]                      core_weights,
  output logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]   core_img [0:IC-1],
  output logic                                 core_start,
  input  logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] core_img_out,
  input  logic                                 core_done,
  output logic                                 busy
);

  localparam int unsigned PIX_IN     = IMG_IN_SIZE * IMG_IN_SIZE;
  localparam int unsigned PIX_OUT    = IMG_OUT_SIZE * IMG_OUT_SIZE;
  localparam int unsigned W_BITS     = IC * 9;
  localparam int unsigned NBITS_IN   = W_BITS + IC * PIX_IN;
  localparam int unsigned NBYTES_IN  = ceil_div8(NBITS_IN);
  localparam int unsigned NBYTES_OUT = ceil_div8(PIX_OUT);
  localparam int unsigned CNT_W      = $clog2(max_u(NBYTES_IN, NBYTES_OUT) + 1);
  localparam int unsigned FLAT_IW    = $clog2(NBITS_IN);
  localparam int unsigned BASE_W     = CNT_W + 3;

  conv_stream_state_t r_state;
  conv_stream_state_t w_state_nxt;

  logic [CNT_W-1:0]    r_byte_cnt;
  logic [NBITS_IN-1:0] r_flat;
  logic                r_in_ready;
  logic                r_core_start;
  logic                r_busy;

  logic                w_in_fire;
  logic                w_in_last;
  logic                w_capture;
  logic                w_send_done_c;
  logic                w_in_ready_nxt;
  logic                w_core_start_nxt;
  logic                w_busy_nxt;
  logic [BASE_W-1:0]   w_bit_base;

  assign w_in_fire  = in_valid && r_in_ready && (r_state == LOAD);
  assign w_in_last  = (r_byte_cnt == CNT_W'(NBYTES_IN - 1));
  assign w_capture  = core_done && (r_state == RUN);
  assign w_bit_base = {r_byte_cnt, 3'b000};

  // Next state plus next values of the registered handshake/status outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_in_ready_nxt   = 1'b0;
    w_core_start_nxt = 1'b0;
    w_busy_nxt       = 1'b1;
    case (r_state)
      LOAD:    if (w_in_fire && w_in_last) w_state_nxt = RUN;
      RUN:     if (core_done) w_state_nxt = SEND;
      SEND:    if (w_send_done_c) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
    case (w_state_nxt)
      LOAD: begin
        w_in_ready_nxt = 1'b1;
        w_busy_nxt     = 1'b0;
      end
      RUN:     w_core_start_nxt = 1'b1;
      default: w_busy_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= LOAD;
      r_in_ready   <= 1'b0;
      r_core_start <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_in_ready   <= w_in_ready_nxt;
      r_core_start <= w_core_start_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  // Byte k bit j lands at flat bit 8k+j; bits past the load vector are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_flat     <= '0;
    end else if (w_in_fire) begin
      for (int j = 0; j < 8; j++) begin
        if (int'(w_bit_base) + j < int'(NBITS_IN))
          r_flat[FLAT_IW'(int'(w_bit_base) + j)] <= in_data[j];
      end
      r_byte_cnt <= w_in_last ? '0 : r_byte_cnt + CNT_W'(1);
    end
  end

  assign core_weights = r_flat[W_BITS-1:0];

  for (genvar c = 0; c < IC; c++) begin : g_img
    assign core_img[c] = r_flat[W_BITS + c*PIX_IN +: PIX_IN];
  end

  conv_result_serializer #(
    .PIX_OUT (PIX_OUT),
    .CNT_W   (CNT_W)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .i_capture   (w_capture),
    .i_result    (core_img_out),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_valid (out_valid),
    .o_done_c    (w_send_done_c)
  );

  assign in_ready   = r_in_ready;
  assign core_start = r_core_start;
  assign busy       = r_busy;

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Self-checking bench: a tiny (IC=1, 4x4) instance for table/corner cases and a
// default-size instance for full-length load and drain against a bit-level model.
module tb_conv_stream_ctrl;

  localparam int unsigned B_NIN  = 909;
  localparam int unsigned B_NOUT = 98;

  logic clk;
  logic rst;

  logic [7:0]  s_in_data;
  logic        s_in_valid;
  logic        s_in_ready;
  logic [7:0]  s_out_data;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [8:0]  s_w;
  logic [15:0] s_img [0:0];
  logic        s_start;
  logic [3:0]  s_res;
  logic        s_done;
  logic        s_busy;

  logic [7:0]   b_in_data;
  logic         b_in_valid;
  logic         b_in_ready;
  logic [7:0]   b_out_data;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [71:0]  b_w;
  logic [899:0] b_img [0:7];
  logic         b_start;
  logic [783:0] b_res;
  logic         b_done;
  logic         b_busy;

  int n_checks;
  int n_errors;

  logic [7:0]   b_bytes [B_NIN];
  logic [783:0] rres;
  logic [31:0]  word;
  logic [3:0]   rnd_res;
  logic [8:0]   ew;
  logic [15:0]  ei;
  logic [7:0]   eo;

  typedef struct {
    logic [31:0] bytes;
    logic [3:0]  res;
    logic [8:0]  exp_w;
    logic [15:0] exp_img;
    logic [7:0]  exp_out;
    int          stall;
  } vec_t;

  vec_t tbl [4];

  conv_stream_ctrl #(.IC(1), .IMG_IN_SIZE(4), .IMG_OUT_SIZE(2)) u_small (
    .clk          (clk),
    .rst          (rst),
    .in_data      (s_in_data),
    .in_valid     (s_in_valid),
    .in_ready     (s_in_ready),
    .out_data     (s_out_data),
    .out_valid    (s_out_valid),
    .out_ready    (s_out_ready),
    .core_weights (s_w),
    .core_img     (s_img),
    .core_start   (s_start),
    .core_img_out (s_res),
    .core_done    (s_done),
    .busy         (s_busy)
  );

  conv_stream_ctrl u_big (
    .clk          (clk),
    .rst          (rst),
    .in_data      (b_in_data),
    .in_valid     (b_in_valid),
    .in_ready     (b_in_ready),
    .out_data     (b_out_data),
    .out_valid    (b_out_valid),
    .out_ready    (b_out_ready),
    .core_weights (b_w),
    .core_img     (b_img),
    .core_start   (b_start),
    .core_img_out (b_res),
    .core_done    (b_done),
    .busy         (b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic check_wide(input string name, input logic [899:0] act, input logic [899:0] expv);
    int first;
    n_checks++;
    if (act !== expv) begin
      first = -1;
      for (int i = 899; i >= 0; i--) if (act[i] !== expv[i]) first = i;
      n_errors++;
      $display("FAIL %s: first differing bit %0d got %b expected %b", name, first,
               act[first], expv[first]);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no handshake, expected one within the cycle bound", name);
  endtask

  task automatic s_send_byte(input logic [7:0] b, input int gap);
    int guard;
    s_in_valid = 1'b0;
    repeat ($urandom_range(0, gap)) tick();
    s_in_data  = b;
    s_in_valid = 1'b1;
    guard = 0;
    while (s_in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) timeout("s_in_ready");
    tick();
    s_in_valid = 1'b0;
  endtask

  task automatic s_load(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) check("s_start_pre", 64'(s_start), 64'd0);
      s_send_byte(w[8*k +: 8], gap);
    end
  endtask

  // Full small-instance transaction: load, run, capture, stall, drain.
  task automatic s_run(input logic [31:0] w, input logic [3:0] res, input logic [8:0] xw,
                       input logic [15:0] ximg, input logic [7:0] xout, input int stall,
                       input int gap, input bit junk);
    s_load(w, gap);
    check("s_start_rise", 64'(s_start), 64'd1);
    check("s_in_ready_run", 64'(s_in_ready), 64'd0);
    check("s_busy_run", 64'(s_busy), 64'd1);
    check("s_weights", 64'(s_w), 64'(xw));
    check("s_img", 64'(s_img[0]), 64'(ximg));
    if (junk) begin
      s_in_valid = 1'b1;
      s_in_data  = 8'($urandom);
    end
    repeat (3) tick();
    check("s_start_hold", 64'(s_start), 64'd1);
    s_res  = res;
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    s_res  = 4'($urandom);
    check("s_first_valid", 64'(s_out_valid), 64'd1);
    check("s_first_data", 64'(s_out_data), 64'(xout));
    check("s_start_drop", 64'(s_start), 64'd0);
    s_out_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("s_stall_data", 64'(s_out_data), 64'(xout));
      check("s_stall_valid", 64'(s_out_valid), 64'd1);
    end
    s_out_ready = 1'b1;
    tick();
    s_out_ready = 1'b0;
    s_in_valid  = 1'b0;
    check("s_end_valid", 64'(s_out_valid), 64'd0);
    check("s_end_in_ready", 64'(s_in_ready), 64'd1);
    check("s_end_busy", 64'(s_busy), 64'd0);
  endtask

  task automatic reset_pulse(input string tag);
    rst = 1'b1;
    tick();
    check({tag, "_in_ready"}, 64'(s_in_ready), 64'd0);
    check({tag, "_start"}, 64'(s_start), 64'd0);
    check({tag, "_busy"}, 64'(s_busy), 64'd0);
    check({tag, "_out_valid"}, 64'(s_out_valid), 64'd0);
    check({tag, "_out_data"}, 64'(s_out_data), 64'd0);
    check({tag, "_weights"}, 64'(s_w), 64'd0);
    check({tag, "_img"}, 64'(s_img[0]), 64'd0);
    rst         = 1'b0;
    s_in_valid  = 1'b0;
    s_done      = 1'b0;
    s_out_ready = 1'b0;
    tick();
    check({tag, "_in_ready_after"}, 64'(s_in_ready), 64'd1);
  endtask

  function automatic logic b_flat(input int i);
    return b_bytes[i/8][i%8];
  endfunction

  task automatic b_send_byte(input logic [7:0] b, input int gap);
    int guard;
    b_in_valid = 1'b0;
    repeat ($urandom_range(0, gap)) tick();
    b_in_data  = b;
    b_in_valid = 1'b1;
    guard = 0;
    while (b_in_ready !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) timeout("b_in_ready");
    tick();
    b_in_valid = 1'b0;
  endtask

  task automatic b_load(input int gap);
    for (int k = 0; k < int'(B_NIN); k++) begin
      b_bytes[k] = 8'($urandom);
      if (k == 100) begin
        b_res  = '1;
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
        check("b_done_in_load_valid", 64'(b_out_valid), 64'd0);
        check("b_done_in_load_busy", 64'(b_busy), 64'd0);
      end
      b_send_byte(b_bytes[k], gap);
    end
  endtask

  task automatic b_check_loaded();
    logic [899:0] x;
    check("b_start_rise", 64'(b_start), 64'd1);
    check("b_in_ready_run", 64'(b_in_ready), 64'd0);
    x = '0;
    for (int i = 0; i < 72; i++) x[i] = b_flat(i);
    check_wide("b_weights", 900'(b_w), x);
    for (int c = 0; c < 8; c++) begin
      x = '0;
      for (int p = 0; p < 900; p++) x[p] = b_flat(72 + c*900 + p);
      check_wide($sformatf("b_img_ch%0d", c), b_img[c], x);
    end
  endtask

  task automatic b_drain(input logic [783:0] res, input bit random_ready);
    int m;
    int cyc;
    m   = 0;
    cyc = 0;
    while (m < int'(B_NOUT) && cyc < 2000) begin
      b_out_ready = random_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      check($sformatf("b_valid_byte%0d", m), 64'(b_out_valid), 64'd1);
      check($sformatf("b_data_byte%0d", m), 64'(b_out_data), 64'(res[8*m +: 8]));
      tick();
      cyc++;
      if (b_out_ready) m++;
    end
    b_out_ready = 1'b0;
    if (m < int'(B_NOUT)) timeout("b_drain");
    if (!random_ready) check("b_drain_cycles", 64'(cyc), 64'(B_NOUT));
    check("b_end_valid", 64'(b_out_valid), 64'd0);
    check("b_end_in_ready", 64'(b_in_ready), 64'd1);
    check("b_end_busy", 64'(b_busy), 64'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    s_in_data   = '0;
    s_in_valid  = 1'b0;
    s_out_ready = 1'b0;
    s_res       = '0;
    s_done      = 1'b0;
    b_in_data   = '0;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b0;
    b_res       = '0;
    b_done      = 1'b0;

    // Flat word 0x123401FF: weights = bits 8..0, image = bits 24..9 = 0x1A00.
    tbl[0] = '{32'h1234_01FF, 4'hA, 9'h1FF, 16'h1A00, 8'h0A, 5};
    tbl[1] = '{32'h0000_0000, 4'hF, 9'h000, 16'h0000, 8'h0F, 0};
    tbl[2] = '{32'hFFFF_FFFF, 4'h0, 9'h1FF, 16'hFFFF, 8'h00, 2};
    tbl[3] = '{32'hA5C3_5A3C, 4'h6, 9'h03C, 16'hE1AD, 8'h06, 1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(s_in_ready), 64'd0);
    check("rst_out_valid", 64'(s_out_valid), 64'd0);
    check("rst_out_data", 64'(s_out_data), 64'd0);
    check("rst_start", 64'(s_start), 64'd0);
    check("rst_busy", 64'(s_busy), 64'd0);
    check("rst_weights", 64'(s_w), 64'd0);
    check("rst_b_in_ready", 64'(b_in_ready), 64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(s_in_ready), 64'd1);
    check("post_rst_b_in_ready", 64'(b_in_ready), 64'd1);

    for (int t = 0; t < 4; t++)
      s_run(tbl[t].bytes, tbl[t].res, tbl[t].exp_w, tbl[t].exp_img, tbl[t].exp_out,
            tbl[t].stall, 1, 1'b0);

    // core_done while idle in LOAD must be ignored.
    s_res  = 4'hF;
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    check("idle_done_valid", 64'(s_out_valid), 64'd0);
    check("idle_done_in_ready", 64'(s_in_ready), 64'd1);
    check("idle_done_busy", 64'(s_busy), 64'd0);
    s_run(tbl[0].bytes, tbl[0].res, tbl[0].exp_w, tbl[0].exp_img, tbl[0].exp_out, 0, 0, 1'b0);

    // Aborts in each phase, each followed by a clean transaction.
    s_send_byte(8'hFF, 0);
    s_send_byte(8'hFF, 0);
    reset_pulse("rst_load");
    s_run(tbl[0].bytes, tbl[0].res, tbl[0].exp_w, tbl[0].exp_img, tbl[0].exp_out, 5, 0, 1'b0);
    s_load(tbl[3].bytes, 0);
    reset_pulse("rst_run");
    s_run(tbl[0].bytes, tbl[0].res, tbl[0].exp_w, tbl[0].exp_img, tbl[0].exp_out, 5, 0, 1'b0);
    s_load(tbl[0].bytes, 0);
    s_res  = 4'hA;
    s_done = 1'b1;
    tick();
    s_done = 1'b0;
    check("pre_rst_send_valid", 64'(s_out_valid), 64'd1);
    reset_pulse("rst_send");
    s_run(tbl[0].bytes, tbl[0].res, tbl[0].exp_w, tbl[0].exp_img, tbl[0].exp_out, 5, 0, 1'b0);

    // Random words with idle gaps and junk in_valid during RUN/SEND.
    for (int it = 0; it < 20; it++) begin
      word    = $urandom;
      rnd_res = 4'($urandom_range(0, 15));
      for (int i = 0; i < 9; i++) ew[i] = word[i];
      for (int p = 0; p < 16; p++) ei[p] = word[9 + p];
      eo = '0;
      for (int j = 0; j < 4; j++) eo[j] = rnd_res[j];
      s_run(word, rnd_res, ew, ei, eo, int'($urandom_range(0, 3)), 2, 1'b1);
    end

    // Default-size instance: all-ones result with ready held, then random result.
    b_load(1);
    b_check_loaded();
    b_res  = '1;
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    b_res  = '0;
    check("b_start_drop", 64'(b_start), 64'd0);
    b_drain('1, 1'b0);

    b_load(2);
    b_check_loaded();
    for (int i = 0; i < 784; i++) rres[i] = 1'($urandom_range(0, 1));
    b_res  = rres;
    b_done = 1'b1;
    tick();
    b_done = 1'b0;
    b_res  = '0;
    b_drain(rres, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
